// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns fetch_pc, keeps one imem request in flight,
// buffers returned words for decode and squashes stale fetches on redirect.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned PC_INCR   = 4,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [31:0]   INCR_C  = 32'(PC_INCR);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } buf_ent_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  buf_ent_t    buf_q [BUF_DEPTH];
  buf_ent_t    head;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic full;
  logic accept;
  logic push;
  logic pop;

  assign full           = (count == DEPTH_C);
  assign imem_req_valid = (state == RUN) && !full && !redirect_valid;
  assign imem_addr      = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // Redirect squashes both the arriving word and the decode handshake.
  assign push       = (state == WAIT) && imem_rsp_valid && !redirect_valid;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready && !redirect_valid;

  assign head     = buf_q[rd_ptr];
  assign inst_out = inst_valid ? head.inst : 32'h0;
  assign inst_pc  = inst_valid ? head.pc   : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      req_pc   <= 32'h0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      // A request still in flight must have its response swallowed later.
      case (state)
        WAIT:    state <= imem_rsp_valid ? RUN : DISCARD;
        DISCARD: state <= DISCARD;
        default: state <= RUN;
      endcase
    end else begin
      case (state)
        RUN: begin
          if (accept) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + INCR_C;
            state    <= WAIT;
          end
        end
        WAIT:    if (imem_rsp_valid) state <= RUN;
        DISCARD: if (imem_rsp_valid) state <= RUN;
        default: state <= RUN;
      endcase
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr] <= '{pc: req_pc, inst: imem_rsp_data};
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized scoreboard bench for fetch_ctrl: a memory responder, a transaction
// model of fetch/flush rules, and a monitor comparing every cycle.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(RESET_PC), .PC_INCR(4), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  // Model: expected decode stream plus what the single outstanding fetch is.
  ent_t        exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_req_pc;
  int          m_out;     // 0 none, 1 live fetch, 2 squashed fetch
  bit          m_known = 1'b0;
  bit          req_exp;
  int          n_chk = 0;
  int          n_err = 0;
  int          delivered = 0;

  // Memory responder state
  int          lat_lo = 1;
  int          lat_hi = 1;
  bit          mem_busy = 1'b0;
  int          mem_cnt;
  logic [31:0] mem_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs mid-cycle and retire the head on handshake.
  always @(negedge clk) begin
    if (!m_known) begin
      req_exp = 1'b0;
    end else begin
      req_exp = (m_out == 0) && (exp_q.size() < DEPTH) && !redirect_valid;
      chk("req_valid", 32'(imem_req_valid), 32'(req_exp));
      chk("imem_addr", imem_addr, m_pc);
      if (exp_q.size() != 0) begin
        chk("inst_valid", 32'(inst_valid), 32'd1);
        chk("inst_pc", inst_pc, exp_q[0].pc);
        chk("inst_out", inst_out, exp_q[0].inst);
        if (inst_ready && !redirect_valid && !reset) begin
          void'(exp_q.pop_front());
          delivered++;
        end
      end else begin
        chk("inst_valid_idle", 32'(inst_valid), 32'd0);
        chk("inst_out_idle", inst_out, 32'd0);
        chk("inst_pc_idle", inst_pc, 32'd0);
      end
    end
  end

  // Model advance: applies the coming edge using the now-stable inputs.
  always begin
    @(negedge clk);
    #1;
    if (reset) begin
      m_known = 1'b1;
      m_pc    = RESET_PC;
      m_out   = 0;
      exp_q.delete();
    end else if (m_known) begin
      if (redirect_valid) begin
        exp_q.delete();
        m_pc = redirect_pc;
        if (m_out == 1) m_out = imem_rsp_valid ? 0 : 2;
      end else if (m_out != 0) begin
        if (imem_rsp_valid) begin
          if (m_out == 1) exp_q.push_back('{pc: m_req_pc, inst: memf(m_req_pc)});
          m_out = 0;
        end
      end else if (req_exp && imem_req_ready) begin
        m_req_pc = m_pc;
        m_pc     = m_pc + 32'd4;
        m_out    = 1;
      end
    end
  end

  // One clock of stimulus; also plays instruction memory.
  task automatic step(input bit rst, input bit redir, input logic [31:0] rpc,
                      input bit iready, input bit mready);
    bit          acc;
    logic [31:0] aaddr;
    bit          rd;
    @(negedge clk);
    acc   = imem_req_valid && imem_req_ready;
    aaddr = imem_addr;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (acc) begin
      mem_busy = 1'b1;
      mem_cnt  = $urandom_range(lat_hi, lat_lo);
      mem_addr = aaddr;
    end
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memf(mem_addr);
        mem_busy       = 1'b0;
      end
    end else if ($urandom_range(0, 15) == 0) begin
      imem_rsp_valid = 1'b1;             // unsolicited response, must be ignored
      imem_rsp_data  = $urandom;
    end
    rd = redir;
    if (rd && imem_rsp_valid && m_out == 2) rd = 1'b0;
    reset          = rst;
    redirect_valid = rd;
    redirect_pc    = rpc;
    inst_ready     = iready;
    imem_req_ready = mready && !mem_busy;
  endtask

  task automatic run(input int n, input bit iready);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, iready, 1'b1);
  endtask

  task automatic wait_live();
    for (int i = 0; i < 40 && m_out != 1; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("wait_live_timeout", 32'(m_out), 32'd1);
  endtask

  initial begin
    reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

    // Sequential fetch, then decode back-pressure filling the buffer
    run(12, 1'b1);
    run(10, 1'b0);
    run(10, 1'b1);

    // Redirect while buffer full and idle
    run(6, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b1);
    run(8, 1'b1);

    // Redirect while waiting, stale response arrives later
    lat_lo = 5; lat_hi = 5;
    wait_live();
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
    run(12, 1'b1);

    // Redirect coincident with the response
    lat_lo = 2; lat_hi = 2;
    wait_live();
    step(1'b0, 1'b1, 32'h0000_0300, 1'b1, 1'b1);
    run(8, 1'b1);

    // Reset mid-fetch with a late response
    lat_lo = 4; lat_hi = 4;
    wait_live();
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    run(12, 1'b1);

    // Address wrap and back-to-back redirects
    lat_lo = 1; lat_hi = 1;
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    run(8, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0040, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0080, 1'b1, 1'b1);
    run(8, 1'b1);

    // Random traffic
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 15) == 0,
           ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0);
    end
    run(10, 1'b1);

    chk("delivered_count_ok", 32'(delivered > 200), 32'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that owns the architectural fetch PC. It issues one instruction-memory request at a time, buffers returned instructions in a small FIFO for decode, and handles redirects. A redirect is a taken-branch target computed by update_pc. On a redirect the block flushes buffered and in-flight fetches. It sits between instruction memory and decode and replaces the free-running PC register.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
PC_INCR, 4, byte increment between sequential fetches
BUF_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_addr  output  32  fetch address (= fetch_pc)
imem_rsp_valid  input  1  read data valid
imem_rsp_data  input  32  returned instruction word
redirect_valid  input  1  taken branch, load fetch_pc from redirect_pc
redirect_pc  input  32  redirect target (pc_out of update_pc)
inst_valid  output  1  buffer head valid to decode
inst_ready  input  1  decode consumes head this cycle
inst_out  output  32  instruction at buffer head
inst_pc  output  32  address of inst_out

Behaviour:
- State: fetch_pc (32), req_pc (32), FSM {RUN, WAIT, DISCARD}, FIFO of {pc,inst} with count 0..BUF_DEPTH.
- Reset (any state, mid-transaction included): fetch_pc=RESET_PC, FSM=RUN, FIFO empty. The cycle after reset: imem_req_valid=0 only if redirect_valid; inst_valid=0, inst_out=0, inst_pc=0. Any response arriving after reset for a pre-reset request is ignored (FSM=RUN drops it).
- Outputs when FIFO empty: inst_out=0, inst_pc=0.
- Issue: imem_req_valid = (FSM==RUN) && (count<BUF_DEPTH) && !redirect_valid. Combinational.
- imem_addr = fetch_pc at all times.
- Accept: on imem_req_valid && imem_req_ready, req_pc<=fetch_pc and fetch_pc<=fetch_pc+PC_INCR (mod 2^32, wraps silently). FSM->WAIT.
- At most one outstanding request. A response is legal no earlier than the cycle after acceptance.
- WAIT: on imem_rsp_valid, push {req_pc, imem_rsp_data} to the FIFO and go to RUN. The next request can issue the following cycle (2-cycle minimum per fetch).
- RUN or no-outstanding: imem_rsp_valid is ignored.
- Output: inst_valid = count!=0, with inst_out/inst_pc driven combinationally from the head. Pop on inst_valid && inst_ready.
- Push and pop in the same cycle: count unchanged, order preserved. Push never occurs when full, because issue is gated by count.
- Redirect has priority over all other events in its cycle:
  - FIFO flushed (count=0; a same-cycle pop and push are both discarded).
  - fetch_pc<=redirect_pc. No request is issued that cycle.
  - FSM: RUN->RUN. WAIT with imem_rsp_valid the same cycle -> RUN, response dropped. WAIT without response -> DISCARD. DISCARD->DISCARD.
- DISCARD: no requests. On imem_rsp_valid, drop the data and go to RUN.
- Back-to-back redirects: the last one wins.
- Latency: redirect at cycle N gives first request for the target at N+1 if RUN, or the cycle after the stale response if DISCARD. That instruction becomes inst_valid the cycle after its response.
- Misaligned redirect_pc is passed through unchanged; alignment checking is not in scope.

Test Plan:
1. Reset, imem ready=1, 1-cycle response latency, inst_ready=1 -> requests at 0x0,0x4,0x8 every 2 cycles; inst_pc sequence 0x0,0x4,0x8 with matching data.
2. inst_ready=0 with BUF_DEPTH=2 -> after 2 responses imem_req_valid stays 0 and fetch_pc=0x8. Release inst_ready -> heads 0x0 then 0x4 pop, and fetching resumes at 0x8.
3. Redirect to 0x100 while FIFO holds 2 entries and FSM=RUN -> inst_valid=0 next cycle; next imem_addr=0x100 with req_valid=1 in the same cycle after redirect.
4. Redirect to 0x200 while WAIT, stale response 3 cycles later -> no request until the stale response, stale data never appears on inst_out; first delivered inst_pc=0x200.
5. Redirect coincident with imem_rsp_valid in WAIT -> response dropped, FSM=RUN, request to target next cycle. Separately, reset asserted in WAIT then a late response -> nothing pushed, first request at RESET_PC.
6. fetch_pc=0xFFFF_FFFC accepted -> next imem_addr=0x0000_0000. Two redirects on consecutive cycles (0x40, 0x80) -> fetching starts at 0x80.
